// File: rtl/alu_exec_stage.sv
// Execute stage of the multicycle MIPS datapath: operand latch, ALU / iterative multiply, regfile writeback.
// Optional multiplier hardware is enabled by defining ALU_MUL_EN; otherwise op 110 behaves as NOP.
module alu_exec_stage #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned ADR_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [ADR_W-1:0] dest_adr,
    input  logic [WIDTH-1:0] data_from_A,
    input  logic [WIDTH-1:0] data_from_B,
    output logic             busy,
    output logic             done,
    output logic             write,
    output logic [ADR_W-1:0] Adr_register_to_save,
    output logic [WIDTH-1:0] data_to_regfile,
    output logic             zero,
    output logic             overflow
);

    localparam int unsigned SH_W  = $clog2(WIDTH);
`ifdef ALU_MUL_EN
    localparam int unsigned CNT_W = $clog2(WIDTH);
`endif

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_SLT = 3'b100,
        OP_SLL = 3'b101,
        OP_MUL = 3'b110,
        OP_NOP = 3'b111
    } op_e;

`ifdef ALU_MUL_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MUL  = 2'd2,
        S_WB   = 2'd3
    } state_e;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd3
    } state_e;
`endif

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    op_e                op_q, op_d;
    logic [ADR_W-1:0]   dest_q, dest_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               write_q, write_d;
    logic [ADR_W-1:0]   adr_q, adr_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               zero_q, zero_d;
    logic               ovf_q, ovf_d;
`ifdef ALU_MUL_EN
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
`endif

    logic [WIDTH-1:0]   sum, diff, alu_res, wb_res;
    logic               add_ovf, sub_ovf, alu_ovf, wb_ovf, wb_entry, signed_lt, writes_c;

    // Single-cycle ALU on the latched operands
    always_comb begin
        sum       = a_q + b_q;
        diff      = a_q - b_q;
        add_ovf   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
        sub_ovf   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
        signed_lt = $signed(a_q) < $signed(b_q);
        alu_res   = '0;
        alu_ovf   = 1'b0;
        case (op_q)
            OP_ADD: begin alu_res = sum;  alu_ovf = add_ovf; end
            OP_SUB: begin alu_res = diff; alu_ovf = sub_ovf; end
            OP_AND: alu_res = a_q & b_q;
            OP_OR:  alu_res = a_q | b_q;
            OP_SLT: alu_res = WIDTH'(signed_lt);
            OP_SLL: alu_res = a_q << b_q[SH_W-1:0];
            default: alu_res = '0;
        endcase
    end

    // NOP, $zero destination and (without the multiplier) op 110 complete without a write
    always_comb begin
        writes_c = (op_q != OP_NOP) && (dest_q != '0);
`ifndef ALU_MUL_EN
        writes_c = writes_c && (op_q != OP_MUL);
`endif
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        dest_d   = dest_q;
        adr_d    = adr_q;
        data_d   = data_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        wb_entry = 1'b0;
        wb_res   = '0;
        wb_ovf   = 1'b0;
`ifdef ALU_MUL_EN
        acc_d    = acc_q;
        cnt_d    = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = data_from_A;
                    b_d     = data_from_B;
                    op_d    = op_e'(op);
                    dest_d  = dest_adr;
                    state_d = S_EXEC;
`ifdef ALU_MUL_EN
                    if (op_e'(op) == OP_MUL) begin
                        state_d = S_MUL;
                        acc_d   = '0;
                        cnt_d   = '0;
                    end
`endif
                end
            end
            S_EXEC: begin
                state_d  = S_WB;
                wb_entry = 1'b1;
                wb_res   = alu_res;
                wb_ovf   = alu_ovf;
            end
`ifdef ALU_MUL_EN
            // One shift-add partial product per clock; A shifts left, B shifts right
            S_MUL: begin
                acc_d = acc_q + (b_q[0] ? a_q : '0);
                a_d   = a_q << 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d  = S_WB;
                    wb_entry = 1'b1;
                    wb_res   = acc_d;
                end
            end
`endif
            S_WB: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (wb_entry) begin
            adr_d  = dest_q;
            data_d = wb_res;
            zero_d = (wb_res == '0);
            ovf_d  = wb_ovf;
        end
        busy_d  = (state_d != S_IDLE);
        done_d  = wb_entry;
        write_d = wb_entry && writes_c;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_ADD;
            dest_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            write_q <= 1'b0;
            adr_q   <= '0;
            data_q  <= '0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef ALU_MUL_EN
            acc_q   <= '0;
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            dest_q  <= dest_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            write_q <= write_d;
            adr_q   <= adr_d;
            data_q  <= data_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
`ifdef ALU_MUL_EN
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign busy                 = busy_q;
    assign done                 = done_q;
    assign write                = write_q;
    assign Adr_register_to_save = adr_q;
    assign data_to_regfile      = data_q;
    assign zero                 = zero_q;
    assign overflow             = ovf_q;

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
Execute stage directly downstream of the register file in the multicycle MIPS datapath. Latches the register file's two read ports (data_to_A / data_to_B) into operand registers A/B on a control-issued start. Runs the selected ALU operation, single-cycle or iterative multiply. Returns the result to the register file's write port (write / Adr_register_to_save / data) with a one-cycle done pulse to control.

Parameters:
WIDTH, 32, datapath width in bits
ADR_W, 5, register address width (32 GPRs)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
start  in  1  issue pulse from control; sampled only in IDLE
op  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT (signed), 101 SLL, 110 MUL, 111 NOP
dest_adr  in  ADR_W  destination register for result
data_from_A  in  WIDTH  register file port A (data_to_A)
data_from_B  in  WIDTH  register file port B (data_to_B)
busy  out  1  high in any state but IDLE
done  out  1  one-cycle completion pulse
write  out  1  register file write enable
Adr_register_to_save  out  ADR_W  write address to register file
data_to_regfile  out  WIDTH  write data to register file
zero  out  1  last result == 0
overflow  out  1  signed overflow of last ADD/SUB

Behaviour:
- Reset (rst=0, async): state IDLE; busy, done, write, zero, overflow = 0; Adr_register_to_save = 0; data_to_regfile = 0; operand/counter regs = 0. Any in-flight op is discarded with no write, including reset mid-MUL.
- FSM states: IDLE, EXEC, MUL, WB.
- IDLE: when start=1 at edge T, latch A, B, op and dest_adr, then go to EXEC; op 110 goes to MUL instead.
- start while busy: ignored; latched operands unchanged.
- EXEC: compute result in one cycle, register it, go to WB at edge T+1.
- MUL: unsigned shift-add, one partial-product step per clock, counter 0..WIDTH-1. Go to WB at edge T+WIDTH. Result = low WIDTH bits of A*B.
- WB: done=1 and write=1 for exactly one cycle, then IDLE.
  - ALU ops: write/done high between edges T+1 and T+2.
  - MUL: write/done high between edges T+WIDTH and T+WIDTH+1.
  - Back-to-back: next start is accepted no earlier than the edge that leaves WB.
- Adr_register_to_save and data_to_regfile are loaded on entry to WB and held until the next WB. zero and overflow update on entry to WB.
- Arithmetic, all results WIDTH bits with wrap-around:
  - ADD/SUB: two's complement. overflow = signed overflow; write still occurs.
  - AND/OR: bitwise.
  - SLT: result 1 if signed A < signed B, else 0.
  - SLL: A << B[log2(WIDTH)-1:0].
  - overflow = 0 for every op other than ADD/SUB.
- dest_adr = 0 ($zero): done pulses, write stays 0.
- NOP (111): result 0, done pulses, write stays 0.

Optional Feature:
ALU_MUL_EN
- Defined: op 110 uses the MUL state as above.
- Undefined: MUL state and multiplier hardware are not built. op 110 is handled exactly like NOP: EXEC path, result 0, done pulses at T+1, write stays 0.

Test Plan:
1. Reset: rst=0 mid-cycle -> busy, done, write, data_to_regfile, zero, overflow all 0 immediately. After release with no start, outputs remain 0.
2. ADD: A=555, B=333, dest 5 -> data_to_regfile=888, Adr_register_to_save=5, write/done high for exactly one cycle at T+1; zero=0, overflow=0.
3. SUB: A=0x7FFFFFFF, B=0xFFFFFFFF -> 0x80000000, overflow=1. Then SLT: A=0xFFFFFFFF, B=1 -> 1, overflow=0.
4. MUL (ALU_MUL_EN): A=7, B=6, dest 3 -> 42, write at edge T+32. start pulses while busy are ignored.
5. MUL with A=0xFFFFFFFF, B=2 -> 0xFFFFFFFE. Without ALU_MUL_EN the same stimulus gives done at T+1 and write=0.
6. ADD with dest 0 -> done pulse, write=0. Reset asserted at cycle 10 of a MUL -> IDLE, no write. A following ADD 1+2 to dest 4 writes 3.
